// File: rtl/button_events.sv
// Per-channel button event generator. Turns clean, clock-synchronous button
// levels into single-cycle press / release / long-press / auto-repeat pulses,
// plus a held level. Each channel runs its own FSM and hold counter.
module button_events #(
    parameter int NIN        = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int CW         = 25,
    parameter int LONG_CNT   = 25000000,
    parameter int REPEAT_CNT = 5000000
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [NIN-1:0] i_sig,
    output logic [NIN-1:0] o_press,
    output logic [NIN-1:0] o_release,
    output logic [NIN-1:0] o_long,
    output logic [NIN-1:0] o_repeat,
    output logic [NIN-1:0] o_held
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Terminal counts: the event fires on the edge where cnt holds the last value.
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CNT - 1);
    localparam logic          POL       = 1'(ACTIVE_LOW != 0);

    // Normalised "pressed" level per channel (1 = pressed).
    logic [NIN-1:0] pressed;
    assign pressed = i_sig ^ {NIN{POL}};

    for (genvar g = 0; g < NIN; g++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          long_q, long_d;
        logic          rep_q, rep_d;

        // State, counter and registered pulse outputs; reset clears everything.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                rep_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
                rep_q   <= rep_d;
            end
        end

        // Next state and pulse decode; release takes priority over long/repeat.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            long_d  = 1'b0;
            rep_d   = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pressed[g]) begin
                        state_d = PRESS;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end
                end
                PRESS: begin
                    if (!pressed[g]) begin
                        state_d = IDLE;
                        rel_d   = 1'b1;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                REPEAT: begin
                    if (!pressed[g]) begin
                        state_d = IDLE;
                        rel_d   = 1'b1;
                    end else if (cnt_q == REP_LAST) begin
                        cnt_d = '0;
                        rep_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign o_press[g]   = press_q;
        assign o_release[g] = rel_q;
        assign o_long[g]    = long_q;
        assign o_repeat[g]  = rep_q;
        assign o_held[g]    = (state_q != IDLE);
    end

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: two instances (active-high and active-low with
// inverted stimulus) are compared against a hold-length reference model.
module tb_button_events;

    localparam int L = 8;
    localparam int R = 3;

    logic       clk;
    logic       rst_n;
    logic [1:0] sig;
    logic [1:0] sig_n;
    logic [1:0] a_press, a_rel, a_long, a_rep, a_held;
    logic [1:0] b_press, b_rel, b_long, b_rep, b_held;

    assign sig_n = ~sig;

    button_events #(.NIN(2), .ACTIVE_LOW(0), .CW(4), .LONG_CNT(L), .REPEAT_CNT(R)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sig(sig),
        .o_press(a_press), .o_release(a_rel), .o_long(a_long),
        .o_repeat(a_rep), .o_held(a_held)
    );

    button_events #(.NIN(2), .ACTIVE_LOW(1), .CW(4), .LONG_CNT(L), .REPEAT_CNT(R)) dut_al (
        .i_clk(clk), .i_rst_n(rst_n), .i_sig(sig_n),
        .o_press(b_press), .o_release(b_rel), .o_long(b_long),
        .o_repeat(b_rep), .o_held(b_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: h[c] = number of consecutive pressed samples so far.
    int         h [2];
    logic [1:0] e_press, e_rel, e_long, e_rep, e_held;
    int         long_seen [2];
    int         rep_seen  [2];

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("press",    a_press, e_press);
        check("release",  a_rel,   e_rel);
        check("long",     a_long,  e_long);
        check("repeat",   a_rep,   e_rep);
        check("held",     a_held,  e_held);
        check("press_al", b_press, e_press);
        check("rel_al",   b_rel,   e_rel);
        check("long_al",  b_long,  e_long);
        check("rep_al",   b_rep,   e_rep);
        check("held_al",  b_held,  e_held);
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) h[c] = 0;
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_held = '0;
    endtask

    // Drive one sample, advance one edge, update the model, check 1 time unit later.
    task automatic step(input logic [1:0] s);
        sig = s;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int c = 0; c < 2; c++) begin
                e_press[c] = 1'b0; e_rel[c] = 1'b0; e_long[c] = 1'b0;
                e_rep[c] = 1'b0; e_held[c] = 1'b0;
                if (s[c]) begin
                    h[c]++;
                    e_held[c]  = 1'b1;
                    e_press[c] = (h[c] == 1);
                    e_long[c]  = (h[c] == L + 1);
                    e_rep[c]   = (h[c] > L + 1) && (((h[c] - L - 1) % R) == 0);
                end else begin
                    e_rel[c] = (h[c] > 0);
                    h[c] = 0;
                end
                if (e_long[c]) long_seen[c]++;
                if (e_rep[c])  rep_seen[c]++;
            end
        end
        #1;
        check_all();
    endtask

    task automatic hold(input logic [1:0] s, input int n);
        for (int k = 0; k < n; k++) step(s);
    endtask

    initial begin
        rst_n = 1'b0;
        sig   = 2'b00;
        model_clear();
        long_seen[0] = 0; long_seen[1] = 0;
        rep_seen[0]  = 0; rep_seen[1]  = 0;

        // Reset held with toggling inputs: outputs stay 0.
        step(2'b11); step(2'b01); step(2'b10); step(2'b00);
        rst_n = 1'b1;
        hold(2'b00, 3);

        // Short hold on ch0.
        hold(2'b01, 5);
        hold(2'b00, 3);

        // Long hold: long at +8, repeats at +11, +14, +17.
        hold(2'b01, 20);
        hold(2'b00, 2);

        // Boundary: exactly L samples (no long), then L+1 samples (long).
        hold(2'b01, L);
        hold(2'b00, 2);
        hold(2'b01, L + 1);
        hold(2'b00, 2);

        // Release then press on consecutive edges.
        hold(2'b01, 3);
        step(2'b00);
        hold(2'b01, 2);
        hold(2'b00, 2);

        // Both channels together, staggered release.
        hold(2'b11, 12);
        hold(2'b10, 4);
        hold(2'b00, 2);

        // Randomized holds: each channel flips with probability 1/8 per edge.
        begin
            logic [1:0] s;
            s = 2'b00;
            for (int k = 0; k < 400; k++) begin
                for (int c = 0; c < 2; c++)
                    if ($urandom_range(0, 7) == 0) s[c] = ~s[c];
                step(s);
            end
        end
        hold(2'b00, 2);

        // ch1 into REPEAT, then asynchronous reset mid-cycle.
        hold(2'b10, 14);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        hold(2'b10, 2);
        rst_n = 1'b1;
        step(2'b10);
        hold(2'b10, 2);
        hold(2'b00, 2);

        // The long and repeat paths were actually exercised.
        total++;
        assert (long_seen[0] > 0 && rep_seen[0] > 0 && long_seen[1] > 0) else begin
            bad++;
            $error("FAIL coverage long0=%0d rep0=%0d long1=%0d required nonzero",
                   long_seen[0], rep_seen[0], long_seen[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
